char_console_writer: RTL and testbench
======================================

// Module: char_console_writer
// PURPOSE
//  Upstream feeder for the screen char RAM write port. Accepts an ASCII byte
//  stream (CPU/UART) over valid/ready and keeps a row/col cursor. Emits
//  single-cycle write strobes: printable chars, backspace erase, row clear on
//  wrap, full-screen clear. No scrolling: bottom row wraps to row 0, which is
//  cleared first.
// PARAMETERS
//  COLS            80  characters per row
//  ROWS            25  rows; COLS*ROWS must be <= 2048 (11-bit address)
//  CLEAR_ON_RESET  1   1: run full clear after reset; 0: start IDLE
// PORTS
//  CLK                  in   1   system clock
//  RST                  in   1   async, active-high reset
//  in_data              in   8   ASCII byte
//  in_valid             in   1   in_data valid
//  in_ready             out  1   high only in IDLE; accept = in_valid & in_ready
//  write_character_pos  out  11  char RAM write address (registered)
//  write_character      out  8   char RAM write data (registered)
//  write_strobe         out  1   one-cycle write enable (registered)
//  cursor_pos           out  11  row*COLS+col (registered)
//  busy                 out  1   ~in_ready
// BEHAVIOUR
//  - One clock; RST asynchronous and active-high. During/at RST: row=col=0,
//    write_strobe=0, write_character_pos=0, write_character=0, cursor_pos=0,
//    clr_cnt=0; state=CLEAR_ALL if CLEAR_ON_RESET else IDLE. RST mid-clear
//    aborts, then restarts from this state.
//  - States: IDLE, CLEAR_ROW, CLEAR_ALL. All outputs registered: action
//    decided at edge E is visible in the cycle after E.
//  - On accept in IDLE (edge ending cycle N), by in_data:
//    0x20-0x7E: write char at row*COLS+col (strobe visible in N+1); col+1.
//      If col was COLS-1: col=0, row advances (see wrap).
//    0x0A LF: col=0, row advances; no char write.
//    0x0D CR: col=0; no write.
//    0x08 BS: if col>0: col-1, write 0x20 at new pos; col==0: no-op.
//    0x0C FF: enter CLEAR_ALL, clr_cnt=0.
//    other bytes: accepted and dropped; no write, cursor unchanged.
//  - Row advance: row+1, ROWS-1 -> 0. Always enters CLEAR_ROW, clr_cnt=0.
//  - CLEAR_ROW: one write/cycle of 0x20 at row*COLS+clr_cnt, clr_cnt 0..COLS-1.
//    IDLE after COLS writes. in_ready low exactly COLS cycles after the accept.
//    Printable char at last col: its write happens at the accept edge. The
//    row-clear writes follow back-to-back in the next COLS cycles.
//  - CLEAR_ALL: writes 0x20 to pos 0..ROWS*COLS-1, one/cycle. Then row=col=0
//    and IDLE.
//  - Strobe never high in IDLE except for the single-cycle char/BS write.
//    No two writes target one address in one cycle.
//  - Widths: row ceil(log2 ROWS), col/clr_cnt ceil(log2 COLS)+1 bits,
//    clr_cnt for CLEAR_ALL 11 bits. pos = row*COLS+col computed in 11 bits;
//    never exceeds ROWS*COLS-1.
//  - cursor_pos updates on the same edge as row/col. After FF it reads 0 once
//    back in IDLE.
// STRUCTURE
//  - Shared include char_console_defs.vh: ASCII_LF/CR/BS/FF/SPACE, state
//    encoding, default COLS/ROWS; also used by the VGA text pipeline.
//  - No sub-module: single FSM + cursor/clear counters. Elaboration-time
//    check that COLS*ROWS <= 2048.
// TESTING
//  1 Reset, CLEAR_ON_RESET=1 -> 2000 strobes, 0x20 at pos 0..1999, then
//    in_ready=1, cursor_pos=0.
//  2 Send 'A','B' -> writes 0x41@0, 0x42@1, each strobe 1 cycle; cursor_pos=2.
//  3 At col 79 row 0 send 'Z' -> 0x5A@79, then 80 writes 0x20@80..159;
//    in_ready low 80 cycles; cursor_pos=80.
//  4 Row 24 send LF -> row 0, writes 0x20@0..79, cursor_pos=0. BS at col 0
//    -> no write. BS at col 5 -> 0x20@4, cursor_pos=4.
//  5 FF mid-screen -> 2000 clear writes, then cursor_pos=0. RST pulsed at
//    clr_cnt=500 -> outputs 0 and the clear restarts at 0.
//  6 Hold in_valid with random stream incl. 0x07,0x7F -> ignored bytes accepted,
//    no strobe; scoreboard screen model matches RAM writes.

Source files
------------

// File: rtl/char_console_writer_pkg.sv
// Shared definitions for the character console writer: ASCII control codes,
// FSM state encoding, default screen geometry and a printable-range helper.
package char_console_writer_pkg;

    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_BS    = 8'h08;
    localparam logic [7:0] ASCII_FF    = 8'h0C;
    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_TILDE = 8'h7E;

    localparam int DEFAULT_COLS = 80;
    localparam int DEFAULT_ROWS = 25;

    // Char RAM address width; the screen must fit in 2048 cells
    localparam int POS_W = 11;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_CLEAR_ROW = 2'd1,
        ST_CLEAR_ALL = 2'd2
    } state_t;

    function automatic logic is_printable(input logic [7:0] c);
        return (c >= ASCII_SPACE) && (c <= ASCII_TILDE);
    endfunction

endpackage

// File: rtl/char_console_writer.sv
// Character console writer: turns an ASCII byte stream into char RAM write
// strobes while tracking a row/col cursor. Handles printable characters,
// LF/CR/BS, form feed (full clear) and clears each new row on entry. There is
// no scrolling; advancing past the bottom row wraps to row 0.
module char_console_writer
    import char_console_writer_pkg::*;
#(
    parameter int COLS           = DEFAULT_COLS,
    parameter int ROWS           = DEFAULT_ROWS,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [POS_W-1:0] write_character_pos,
    output logic [7:0]       write_character,
    output logic             write_strobe,
    output logic [POS_W-1:0] cursor_pos,
    output logic             busy
);

    localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int COL_W = $clog2(COLS) + 1;
    localparam int TOTAL = COLS * ROWS;

    localparam logic [ROW_W-1:0] ROW_LAST     = ROW_W'(ROWS - 1);
    localparam logic [COL_W-1:0] COL_LAST     = COL_W'(COLS - 1);
    localparam logic [POS_W-1:0] CNT_ROW_LAST = POS_W'(COLS - 1);
    localparam logic [POS_W-1:0] CNT_ALL_LAST = POS_W'(TOTAL - 1);
    localparam state_t           RESET_STATE  = CLEAR_ON_RESET ? ST_CLEAR_ALL : ST_IDLE;

    // Screen geometry has to fit the 11-bit char RAM address space
    if (TOTAL > (1 << POS_W)) begin : g_size_check
        $error("char_console_writer: COLS*ROWS exceeds the 2048-cell char RAM");
    end

    state_t             state, state_nxt;
    logic [ROW_W-1:0]   row, row_nxt;
    logic [COL_W-1:0]   col, col_nxt;
    logic [POS_W-1:0]   clr_cnt, clr_cnt_nxt;
    logic               wr_nxt;
    logic [POS_W-1:0]   wr_pos_nxt;
    logic [7:0]         wr_char_nxt;
    logic               accept;

    // Linear char RAM address of a (row, col) pair
    function automatic logic [POS_W-1:0] pos_of(input int r, input int c);
        return POS_W'(r * COLS + c);
    endfunction

    assign in_ready = (state == ST_IDLE);
    assign busy     = ~in_ready;
    assign accept   = in_valid & in_ready;

    // Next-state, cursor movement and write decode for the current cycle
    always_comb begin
        state_nxt   = state;
        row_nxt     = row;
        col_nxt     = col;
        clr_cnt_nxt = clr_cnt;
        wr_nxt      = 1'b0;
        wr_pos_nxt  = write_character_pos;
        wr_char_nxt = write_character;

        unique case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (is_printable(in_data)) begin
                        wr_nxt      = 1'b1;
                        wr_pos_nxt  = pos_of(int'(row), int'(col));
                        wr_char_nxt = in_data;
                        if (col == COL_LAST) begin
                            // Wrap: the char write goes out now, the new row is cleared next
                            col_nxt     = '0;
                            row_nxt     = (row == ROW_LAST) ? '0 : row + ROW_W'(1);
                            state_nxt   = ST_CLEAR_ROW;
                            clr_cnt_nxt = '0;
                        end else begin
                            col_nxt = col + COL_W'(1);
                        end
                    end else if (in_data == ASCII_LF) begin
                        col_nxt     = '0;
                        row_nxt     = (row == ROW_LAST) ? '0 : row + ROW_W'(1);
                        state_nxt   = ST_CLEAR_ROW;
                        clr_cnt_nxt = '0;
                    end else if (in_data == ASCII_CR) begin
                        col_nxt = '0;
                    end else if (in_data == ASCII_BS) begin
                        // Backspace at column 0 is a no-op
                        if (col != '0) begin
                            col_nxt     = col - COL_W'(1);
                            wr_nxt      = 1'b1;
                            wr_pos_nxt  = pos_of(int'(row), int'(col) - 1);
                            wr_char_nxt = ASCII_SPACE;
                        end
                    end else if (in_data == ASCII_FF) begin
                        state_nxt   = ST_CLEAR_ALL;
                        clr_cnt_nxt = '0;
                    end
                end
            end
            ST_CLEAR_ROW: begin
                wr_nxt      = 1'b1;
                wr_pos_nxt  = pos_of(int'(row), int'(clr_cnt));
                wr_char_nxt = ASCII_SPACE;
                if (clr_cnt == CNT_ROW_LAST) begin
                    state_nxt   = ST_IDLE;
                    clr_cnt_nxt = '0;
                end else begin
                    clr_cnt_nxt = clr_cnt + POS_W'(1);
                end
            end
            ST_CLEAR_ALL: begin
                wr_nxt      = 1'b1;
                wr_pos_nxt  = clr_cnt;
                wr_char_nxt = ASCII_SPACE;
                if (clr_cnt == CNT_ALL_LAST) begin
                    // Home the cursor once the whole screen is blank
                    state_nxt   = ST_IDLE;
                    clr_cnt_nxt = '0;
                    row_nxt     = '0;
                    col_nxt     = '0;
                end else begin
                    clr_cnt_nxt = clr_cnt + POS_W'(1);
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // State, cursor and registered write-port outputs
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state               <= RESET_STATE;
            row                 <= '0;
            col                 <= '0;
            clr_cnt             <= '0;
            write_strobe        <= 1'b0;
            write_character_pos <= '0;
            write_character     <= '0;
            cursor_pos          <= '0;
        end else begin
            state               <= state_nxt;
            row                 <= row_nxt;
            col                 <= col_nxt;
            clr_cnt             <= clr_cnt_nxt;
            write_strobe        <= wr_nxt;
            write_character_pos <= wr_pos_nxt;
            write_character     <= wr_char_nxt;
            cursor_pos          <= pos_of(int'(row_nxt), int'(col_nxt));
        end
    end

endmodule

// File: tb/tb_char_console_writer.sv
// Testbench for char_console_writer: a screen/cursor reference model pushes
// expected RAM writes into a scoreboard queue; a monitor pops and compares
// each strobe the DUT emits.
module tb_char_console_writer;

    localparam int COLS  = 80;
    localparam int ROWS  = 25;
    localparam int TOTAL = COLS * ROWS;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [10:0] write_character_pos;
    logic [7:0]  write_character;
    logic        write_strobe;
    logic [10:0] cursor_pos;
    logic        busy;

    char_console_writer #(
        .COLS(COLS),
        .ROWS(ROWS),
        .CLEAR_ON_RESET(1'b1)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .in_data(in_data),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .write_character_pos(write_character_pos),
        .write_character(write_character),
        .write_strobe(write_strobe),
        .cursor_pos(cursor_pos),
        .busy(busy)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int         pos;
        logic [7:0] ch;
    } wr_t;

    wr_t        sb[$];
    int         checks = 0;
    int         passes = 0;
    int         writes_seen = 0;
    logic [7:0] screen[TOTAL];
    logic [7:0] ram[TOTAL];
    int         m_row = 0;
    int         m_col = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    endtask

    // ---------------- reference model ----------------
    function automatic void exp_write(input int pos, input logic [7:0] ch);
        wr_t w;
        w.pos = pos;
        w.ch  = ch;
        sb.push_back(w);
        screen[pos] = ch;
    endfunction

    function automatic void new_row();
        m_row = (m_row + 1) % ROWS;
        for (int i = 0; i < COLS; i++) exp_write(m_row * COLS + i, 8'h20);
    endfunction

    function automatic void clear_all();
        for (int i = 0; i < TOTAL; i++) exp_write(i, 8'h20);
        m_row = 0;
        m_col = 0;
    endfunction

    function automatic void model_accept(input logic [7:0] b);
        if (b >= 8'h20 && b <= 8'h7E) begin
            exp_write(m_row * COLS + m_col, b);
            m_col++;
            if (m_col == COLS) begin
                m_col = 0;
                new_row();
            end
        end else begin
            case (b)
                8'h0A: begin m_col = 0; new_row(); end
                8'h0D: m_col = 0;
                8'h08: if (m_col > 0) begin m_col--; exp_write(m_row * COLS + m_col, 8'h20); end
                8'h0C: clear_all();
                default: ;
            endcase
        end
    endfunction

    // ---------------- monitor ----------------
    always @(negedge CLK) begin : monitor
        wr_t e;
        if (write_strobe) begin
            writes_seen++;
            if (sb.size() == 0) begin
                checks++;
                $display("FAIL unexpected_strobe: got write 0x%0h@%0d, expected no write",
                         write_character, write_character_pos);
            end else begin
                e = sb.pop_front();
                chk("wr_pos", int'(write_character_pos), e.pos);
                chk("wr_char", int'(write_character), int'(e.ch));
            end
            if (int'(write_character_pos) < TOTAL) ram[write_character_pos] = write_character;
        end
    end

    // ---------------- driver helpers ----------------
    task automatic send(input logic [7:0] b, input bit hold);
        int n = 0;
        @(negedge CLK);
        while (!in_ready && n < 5000) begin
            @(negedge CLK);
            n++;
        end
        if (!in_ready) begin
            chk("send_timeout", 0, 1);
            return;
        end
        in_data  = b;
        in_valid = 1'b1;
        model_accept(b);
        @(posedge CLK);
        #1;
        if (!hold) in_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        @(negedge CLK);
        while (!in_ready && n < 5000) begin
            @(negedge CLK);
            n++;
        end
        chk({name, "_ready"}, int'(in_ready), 1);
        chk({name, "_busy"}, int'(busy), 0);
        chk({name, "_cursor"}, int'(cursor_pos), m_row * COLS + m_col);
    endtask

    task automatic check_reset_outputs(input string name);
        chk({name, "_strobe"}, int'(write_strobe), 0);
        chk({name, "_wpos"}, int'(write_character_pos), 0);
        chk({name, "_wchar"}, int'(write_character), 0);
        chk({name, "_cursor"}, int'(cursor_pos), 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin : stim
        int low;
        int base;
        int n;
        int mism;
        int r;
        logic [7:0] b;
        logic [7:0] hello[5];

        for (int i = 0; i < TOTAL; i++) begin
            screen[i] = 8'h00;
            ram[i]    = 8'h00;
        end

        // Reset with clear-on-reset: full 2000-cell blanking follows
        #1 RST = 1'b1;
        repeat (3) @(negedge CLK);
        check_reset_outputs("reset");
        chk("reset_busy", int'(busy), 1);
        clear_all();
        RST = 1'b0;
        wait_idle("reset_clear");
        @(negedge CLK);
        chk("reset_clear_count", writes_seen, TOTAL);
        chk("reset_clear_cursor", int'(cursor_pos), 0);

        // 'A','B' at the home position
        send(8'h41, 1'b0);
        send(8'h42, 1'b0);
        wait_idle("ab");
        chk("ab_cursor_abs", int'(cursor_pos), 2);

        // Fill row 0 to column 79, then wrap with 'Z'
        for (int i = 0; i < 77; i++) send(8'h61 + 8'(i % 26), 1'b0);
        chk("col79_cursor", int'(cursor_pos), 79);
        send(8'h5A, 1'b0);
        low = 0;
        @(negedge CLK);
        while (!in_ready && low < 1000) begin
            low++;
            @(negedge CLK);
        end
        chk("wrap_ready_low", low, COLS);
        chk("wrap_cursor", int'(cursor_pos), 80);

        // LF down to row 24, then LF wraps to row 0
        for (int i = 0; i < 23; i++) send(8'h0A, 1'b0);
        wait_idle("row24");
        chk("row24_cursor_abs", int'(cursor_pos), 24 * COLS);
        send(8'h0A, 1'b0);
        wait_idle("lf_wrap");
        chk("lf_wrap_cursor_abs", int'(cursor_pos), 0);

        // BS at column 0 is a no-op; BS at column 5 erases column 4
        @(negedge CLK);
        base = writes_seen;
        send(8'h08, 1'b0);
        repeat (3) @(negedge CLK);
        chk("bs_col0_no_write", writes_seen, base);
        chk("bs_col0_cursor", int'(cursor_pos), 0);
        hello = '{8'h68, 8'h65, 8'h6C, 8'h6C, 8'h6F};
        for (int i = 0; i < 5; i++) send(hello[i], 1'b0);
        send(8'h08, 1'b0);
        wait_idle("bs");
        chk("bs_cursor_abs", int'(cursor_pos), 4);

        // FF mid-screen
        send(8'h0A, 1'b0);
        send(8'h71, 1'b0);
        send(8'h72, 1'b0);
        send(8'h0C, 1'b0);
        wait_idle("ff");
        chk("ff_cursor_abs", int'(cursor_pos), 0);

        // RST pulsed roughly 500 writes into a form-feed clear
        @(negedge CLK);
        send(8'h71, 1'b0);
        send(8'h0C, 1'b0);
        base = writes_seen;
        n = 0;
        while ((writes_seen - base) < 501 && n < 5000) begin
            @(negedge CLK);
            n++;
        end
        chk("ff_progress_timeout", int'(n < 5000), 1);
        #2 RST = 1'b1;
        sb.delete();
        #1;
        check_reset_outputs("mid_clear_reset");
        repeat (2) @(negedge CLK);
        clear_all();
        RST = 1'b0;
        wait_idle("rst_restart");
        @(negedge CLK);
        chk("rst_restart_drained", sb.size(), 0);

        // Ignored bytes are accepted without any write or cursor motion
        send(8'h41, 1'b0);
        wait_idle("pre_ignore");
        @(negedge CLK);
        base = writes_seen;
        send(8'h07, 1'b1);
        send(8'h7F, 1'b1);
        in_valid = 1'b0;
        repeat (3) @(negedge CLK);
        chk("ignored_no_write", writes_seen, base);
        chk("ignored_cursor", int'(cursor_pos), 1);

        // Random stream with in_valid held high
        for (int i = 0; i < 300; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 70)      b = 8'($urandom_range(32, 126));
            else if (r < 76) b = 8'h0A;
            else if (r < 80) b = 8'h0D;
            else if (r < 86) b = 8'h08;
            else if (r < 90) b = 8'h07;
            else if (r < 94) b = 8'h7F;
            else if (r < 97) b = 8'($urandom_range(128, 255));
            else             b = 8'h1B;
            send(b, 1'b1);
        end
        in_valid = 1'b0;
        wait_idle("random");

        n = 0;
        while (sb.size() != 0 && n < 10000) begin
            @(negedge CLK);
            n++;
        end
        repeat (5) @(negedge CLK);
        chk("sb_drained", sb.size(), 0);
        mism = 0;
        for (int i = 0; i < TOTAL; i++) if (ram[i] !== screen[i]) mism++;
        chk("screen_match", mism, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
